lenet_result_display: RTL and testbench

Output stage downstream of the LeNet-5 classifier core. Captures the 10×8-bit output-node vector when the core raises its finish flag and scans it sequentially to find the arg-max class. Drives the board's 8-digit multiplexed 7-segment display and status RGB LED with:
- the winning class,
- the input graph number,
- optionally, the winning score.

---
 rtl/lenet_disp_pkg.sv | 22 ++
 rtl/lenet_result_display_if.sv | 21 ++
 rtl/seg7_decoder.sv | 14 +
 rtl/lenet_result_display.sv | 182 ++++++++++++++++++
 tb/tb_lenet_result_display.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/lenet_disp_pkg.sv
// Shared constants, FSM state type and the hex glyph table for the LeNet result display.
package lenet_disp_pkg;

    localparam int unsigned OUTPUT_NODE = 10;
    localparam int unsigned DATA_SIZE   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

endpackage

// File: rtl/lenet_result_display_if.sv
// Classifier-core side of the result display: score vector, done flag, graph index, arg-max result.
interface lenet_result_display_if;
    import lenet_disp_pkg::*;

    logic [OUTPUT_NODE*DATA_SIZE-1:0] result;
    logic                             lenet_finish;
    logic [4:0]                       graph;
    logic [3:0]                       class_idx;
    logic                             class_valid;

    modport master (
        output result, lenet_finish, graph,
        input  class_idx, class_valid
    );

    modport slave (
        input  result, lenet_finish, graph,
        output class_idx, class_valid
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex digit to active-low 7-segment pattern, with a blanking override.
module seg7_decoder
    import lenet_disp_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : HEX_GLYPH[value];
    end

endmodule

// File: rtl/lenet_result_display.sv
// Captures the LeNet output vector on finish, scans for the arg-max, and drives the 8-digit display.
// Optional macro DISPLAY_SCORE_EN: shows the winning score in hex on digits 4 (low) and 5 (high).
module lenet_result_display
    import lenet_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    lenet_result_display_if.slave      core,
    output logic [7:0]                 an,
    output logic [7:0]                 a_to_g,
    output logic [2:0]                 led_rgb
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
    localparam logic [3:0] LastIdx = 4'(OUTPUT_NODE);

    state_e                           state_q, state_d;
    logic                             finish_q;  // lenet_finish delayed one cycle
    logic [OUTPUT_NODE*DATA_SIZE-1:0] shadow_q;
    logic signed [DATA_SIZE-1:0]      best_val_q, best_val_d, node_cur;
    logic [3:0]                       best_idx_q, best_idx_d, idx_q, idx_d, idx_sel;
    logic [3:0]                       class_idx_q, class_idx_d;
    logic                             class_valid_q, class_valid_d;
    logic                             rise;

    assign rise    = core.lenet_finish & ~finish_q;
    assign idx_sel = (idx_q < LastIdx) ? idx_q : 4'd0;
    assign node_cur = shadow_q[idx_sel*DATA_SIZE +: DATA_SIZE];

    always_comb begin
        state_d       = state_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        idx_d         = idx_q;
        class_idx_d   = class_idx_q;
        class_valid_d = class_valid_q;
        if (rise) begin
            // Restart from any state; node 0 seeds the running best directly from the input.
            state_d       = StScan;
            best_val_d    = core.result[DATA_SIZE-1:0];
            best_idx_d    = 4'd0;
            idx_d         = 4'd1;
            class_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StScan: begin
                    if (idx_q == LastIdx) begin
                        class_idx_d   = best_idx_q;
                        class_valid_d = 1'b1;
                        state_d       = StDone;
                    end else begin
                        if (node_cur > best_val_q) begin
                            best_val_d = node_cur;
                            best_idx_d = idx_q;
                        end
                        idx_d = idx_q + 4'd1;
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            StScan:  led_rgb = 3'b100;
            StDone:  led_rgb = 3'b010;
            default: led_rgb = 3'b001;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= StIdle;
            finish_q      <= 1'b0;
            shadow_q      <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            idx_q         <= '0;
            class_idx_q   <= '0;
            class_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            finish_q      <= core.lenet_finish;
            if (rise) shadow_q <= core.result;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            idx_q         <= idx_d;
            class_idx_q   <= class_idx_d;
            class_valid_q <= class_valid_d;
        end
    end

    assign core.class_idx   = class_idx_q;
    assign core.class_valid = class_valid_q;

`ifdef DISPLAY_SCORE_EN
    logic [DATA_SIZE-1:0] score_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            score_q <= '0;
        end else if (!rise && state_q == StScan && idx_q == LastIdx) begin
            score_q <= best_val_q;
        end
    end
`endif

    // Display multiplexing
    logic [CntW-1:0] refresh_q;
    logic [2:0]      ptr_q;
    logic [7:0]      an_q, seg_q, seg_dec;
    logic [3:0]      dig_val, graph_ones, graph_tens;
    logic            dig_blank, dig_dash;

    assign graph_ones = 4'(core.graph % 5'd10);
    assign graph_tens = 4'(core.graph / 5'd10);

    always_comb begin
        dig_val   = 4'd0;
        dig_blank = 1'b1;
        dig_dash  = 1'b0;
        unique case (ptr_q)
            3'd0: begin
                dig_val   = class_idx_q;
                dig_blank = ~class_valid_q;
                dig_dash  = ~class_valid_q;
            end
            3'd2: begin
                dig_val   = graph_ones;
                dig_blank = 1'b0;
            end
            3'd3: begin
                dig_val   = graph_tens;
                dig_blank = 1'b0;
            end
`ifdef DISPLAY_SCORE_EN
            3'd4: begin
                dig_val   = score_q[3:0];
                dig_blank = ~class_valid_q;
            end
            3'd5: begin
                dig_val   = score_q[7:4];
                dig_blank = ~class_valid_q;
            end
`endif
            default: ;
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .value (dig_val),
        .blank (dig_blank),
        .seg   (seg_dec)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            refresh_q <= '0;
            ptr_q     <= '0;
            an_q      <= 8'hFF;
            seg_q     <= SEG_BLANK;
        end else begin
            if (refresh_q == CntMax) begin
                refresh_q <= '0;
                ptr_q     <= ptr_q + 3'd1;
            end else begin
                refresh_q <= refresh_q + 1'b1;
            end
            an_q  <= ~(8'b1 << ptr_q);
            seg_q <= dig_dash ? SEG_DASH : seg_dec;
        end
    end

    assign an     = an_q;
    assign a_to_g = seg_q;

endmodule

// File: tb/tb_lenet_result_display.sv
// Directed self-checking bench for lenet_result_display (REFRESH_DIV=4).
module tb_lenet_result_display;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] an, a_to_g;
    logic [2:0] led_rgb;
    int         errors = 0;
    int         checks = 0;
    int         cyc;
    logic [7:0] exp_seg [8];

    lenet_result_display_if bus ();

    lenet_result_display #(
        .REFRESH_DIV (4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .core      (bus),
        .an        (an),
        .a_to_g    (a_to_g),
        .led_rgb   (led_rgb)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a given digit enable pattern; reports cycles spent waiting.
    task automatic wait_an(input logic [7:0] target, output int n);
        n = 0;
        while (an !== target && n < 100) begin
            step();
            n++;
        end
        check("an_reached", {24'd0, an}, {24'd0, target});
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 10; i++) bus.result[i*8 +: 8] = v;
    endtask

    task automatic show_digit(input string tag, input int k, input logic [7:0] exp);
        logic [7:0] pat;
        pat = ~(8'b1 << k);
        wait_an(pat, cyc);
        check(tag, {24'd0, a_to_g}, {24'd0, exp});
    endtask

    initial begin
        exp_seg = '{8'hFD, 8'hFF, 8'h1F, 8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sys_rst_n        = 1'b0;
        bus.lenet_finish = 1'b0;
        bus.graph        = 5'd17;
        bus.result       = '0;
        repeat (5) step();
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_seg", {24'd0, a_to_g}, 32'hFF);
        check("rst_valid", {31'd0, bus.class_valid}, 32'd0);
        check("rst_idx", {28'd0, bus.class_idx}, 32'd0);
        check("rst_led", {29'd0, led_rgb}, 32'd1);
        sys_rst_n = 1'b1;

        // Display sweep with no result, graph=17
        for (int k = 0; k < 8; k++) begin
            logic [7:0] pat;
            pat = ~(8'b1 << k);
            wait_an(pat, cyc);
            if (k > 0) check("scan_period", cyc, 4);
            check("scan_seg", {24'd0, a_to_g}, {24'd0, exp_seg[k]});
        end
        wait_an(8'hFE, cyc);
        check("scan_wrap_period", cyc, 4);
        check("idle_valid", {31'd0, bus.class_valid}, 32'd0);

        // Basic arg-max: node3 wins
        fill(8'h10);
        bus.result[3*8 +: 8] = 8'h40;
        bus.lenet_finish = 1'b1;
        step();
        check("basic_led_scan", {29'd0, led_rgb}, 32'b100);
        repeat (9) step();
        check("basic_valid_early", {31'd0, bus.class_valid}, 32'd0);
        step();
        check("basic_valid", {31'd0, bus.class_valid}, 32'd1);
        check("basic_idx", {28'd0, bus.class_idx}, 32'd3);
        check("basic_led_done", {29'd0, led_rgb}, 32'b010);
        show_digit("basic_d0", 0, 8'h0D);
`ifdef DISPLAY_SCORE_EN
        show_digit("basic_d4", 4, 8'h03);
        show_digit("basic_d5", 5, 8'h99);
`endif

        // Signed compare: -128 and -16 lose to +5 at node9
        bus.lenet_finish = 1'b0;
        step();
        fill(8'hF0);
        bus.result[0 +: 8]   = 8'h80;
        bus.result[9*8 +: 8] = 8'h05;
        bus.lenet_finish = 1'b1;
        repeat (11) step();
        check("signed_valid", {31'd0, bus.class_valid}, 32'd1);
        check("signed_idx", {28'd0, bus.class_idx}, 32'd9);
        show_digit("signed_d0", 0, 8'h09);
`ifdef DISPLAY_SCORE_EN
        show_digit("signed_d4", 4, 8'h49);
        show_digit("signed_d5", 5, 8'h03);
`endif

        // Tie keeps lowest index; later input changes must not affect the scan
        bus.lenet_finish = 1'b0;
        step();
        fill(8'h00);
        bus.result[2*8 +: 8] = 8'h55;
        bus.result[7*8 +: 8] = 8'h55;
        bus.lenet_finish = 1'b1;
        step();
        bus.result[8*8 +: 8] = 8'h7F;
        repeat (10) step();
        check("tie_idx", {28'd0, bus.class_idx}, 32'd2);
        show_digit("tie_d0", 0, 8'h25);
`ifdef DISPLAY_SCORE_EN
        show_digit("tie_d4", 4, 8'h49);
        show_digit("tie_d5", 5, 8'h49);
`endif

        // Reset mid-scan at T+4
        bus.lenet_finish = 1'b0;
        step();
        fill(8'h00);
        bus.result[5*8 +: 8] = 8'h30;
        bus.lenet_finish = 1'b1;
        step();
        repeat (3) step();
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        bus.lenet_finish = 1'b0;
        check("midrst_valid", {31'd0, bus.class_valid}, 32'd0);
        check("midrst_led", {29'd0, led_rgb}, 32'b001);
        check("midrst_idx", {28'd0, bus.class_idx}, 32'd0);
        repeat (12) step();
        check("midrst_idle_valid", {31'd0, bus.class_valid}, 32'd0);
        check("midrst_idle_led", {29'd0, led_rgb}, 32'b001);
        bus.lenet_finish = 1'b1;
        repeat (10) step();
        check("rerun_valid_early", {31'd0, bus.class_valid}, 32'd0);
        step();
        check("rerun_valid", {31'd0, bus.class_valid}, 32'd1);
        check("rerun_idx", {28'd0, bus.class_idx}, 32'd5);

        // Finish held high through reset counts as a rise on the first edge after release
        sys_rst_n = 1'b0;
        fill(8'h01);
        bus.result[6*8 +: 8] = 8'h22;
        step();
        step();
        sys_rst_n = 1'b1;
        repeat (10) step();
        check("hold_valid_early", {31'd0, bus.class_valid}, 32'd0);
        step();
        check("hold_valid", {31'd0, bus.class_valid}, 32'd1);
        check("hold_idx", {28'd0, bus.class_idx}, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
